// File: rtl/synth_pkg.sv
// Shared types and MIDI constants for the voice allocator.
package synth_pkg;

    localparam int unsigned KEY_W       = 7;
    localparam int unsigned VEL_W       = 7;
    // Table stamps are stored at this width; only the low STAMP_W bits carry age.
    localparam int unsigned STAMP_MAX_W = 16;

    typedef struct packed {
        logic [KEY_W-1:0]       key;
        logic                   held;
        logic [STAMP_MAX_W-1:0] stamp;
    } voice_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE
    } state_t;

    // Ordered so that a numerically larger kind always wins.
    typedef enum logic [1:0] {
        CAND_NONE,
        CAND_STEAL,
        CAND_FREE,
        CAND_RETRIG
    } cand_t;

endpackage

// File: rtl/voice_scan_cmp.sv
// Combinational compare of one scanned voice entry against the current event
// and the running best steal candidate.
module voice_scan_cmp
    import synth_pkg::*;
#(
    parameter int unsigned STAMP_W = 8
) (
    input  voice_entry_t       entry,
    input  logic               active,
    input  logic [KEY_W-1:0]   key,
    input  logic [STAMP_W-1:0] stamp_ctr,
    input  logic [STAMP_W-1:0] best_age,
    output logic               retrig_c,
    output logic               free_c,
    output logic               held_match_c,
    output logic               age_gt_c,
    output logic [STAMP_W-1:0] age_c
);

    logic key_match;

    assign key_match    = (entry.key == key);
    assign retrig_c     = key_match && (entry.held || active);
    assign free_c       = !entry.held && !active;
    assign held_match_c = key_match && entry.held;
    // Modular age: wraps with the stamp counter.
    assign age_c        = STAMP_W'(STAMP_MAX_W'(stamp_ctr) - entry.stamp);
    assign age_gt_c     = (age_c > best_age);

endmodule

// File: rtl/voice_allocator.sv
// Maps MIDI note events onto NUM_VOICES voice slots with retrigger/free/oldest-steal
// priority. Define VOICE_STEAL_EN to enable stealing; otherwise a full table drops.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned STAMP_W    = 8
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          EVT_VALID,
    output logic                          EVT_READY,
    input  logic                          EVT_ON,
    input  logic [KEY_W-1:0]              EVT_KEY,
    input  logic [VEL_W-1:0]              EVT_VEL,
    input  logic [NUM_VOICES-1:0]         VOICE_ACTIVE,
    output logic [$clog2(NUM_VOICES)-1:0] V_SEL,
    output logic [KEY_W-1:0]              V_KEY,
    output logic [VEL_W-1:0]              V_VEL,
    output logic                          V_LD,
    output logic                          V_NOTE_ON,
    output logic                          V_NOTE_OFF,
    output logic                          STEAL,
    output logic                          DROP
);

    localparam int unsigned SEL_W = $clog2(NUM_VOICES);

    state_t             state;
    logic [SEL_W-1:0]   idx;
    logic [KEY_W-1:0]   evt_key;
    logic [VEL_W-1:0]   evt_vel;
    logic               evt_on;
    voice_entry_t       tbl [NUM_VOICES];
    logic [STAMP_W-1:0] stamp_ctr;
    cand_t              best_kind;
    logic [SEL_W-1:0]   best_idx;
    logic [STAMP_W-1:0] best_age;
    logic               off_found;
    logic [SEL_W-1:0]   off_idx;

    logic               retrig_c;
    logic               free_c;
    logic               held_match_c;
    logic               age_gt_c;
    logic [STAMP_W-1:0] age_c;
    logic               do_load_c;

    voice_scan_cmp #(
        .STAMP_W (STAMP_W)
    ) u_cmp (
        .entry        (tbl[idx]),
        .active       (VOICE_ACTIVE[idx]),
        .key          (evt_key),
        .stamp_ctr    (stamp_ctr),
        .best_age     (best_age),
        .retrig_c     (retrig_c),
        .free_c       (free_c),
        .held_match_c (held_match_c),
        .age_gt_c     (age_gt_c),
        .age_c        (age_c)
    );

    // Decide at ISSUE whether the chosen candidate may be loaded.
    always_comb begin
        do_load_c = 1'b0;
`ifdef VOICE_STEAL_EN
        do_load_c = evt_on && (best_kind != CAND_NONE);
`else
        do_load_c = evt_on && ((best_kind == CAND_FREE) || (best_kind == CAND_RETRIG));
`endif
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            EVT_READY  <= 1'b0;
            idx        <= '0;
            evt_key    <= '0;
            evt_vel    <= '0;
            evt_on     <= 1'b0;
            stamp_ctr  <= '0;
            best_kind  <= CAND_NONE;
            best_idx   <= '0;
            best_age   <= '0;
            off_found  <= 1'b0;
            off_idx    <= '0;
            V_SEL      <= '0;
            V_KEY      <= '0;
            V_VEL      <= '0;
            V_LD       <= 1'b0;
            V_NOTE_ON  <= 1'b0;
            V_NOTE_OFF <= 1'b0;
            STEAL      <= 1'b0;
            DROP       <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                tbl[i] <= '0;
            end
        end else begin
            V_LD       <= 1'b0;
            V_NOTE_ON  <= 1'b0;
            V_NOTE_OFF <= 1'b0;
            STEAL      <= 1'b0;
            DROP       <= 1'b0;
            EVT_READY  <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (EVT_VALID && EVT_READY) begin
                        evt_key   <= EVT_KEY;
                        evt_vel   <= EVT_VEL;
                        // Velocity-zero note-on is a note-off.
                        evt_on    <= EVT_ON && (EVT_VEL != '0);
                        idx       <= '0;
                        best_kind <= CAND_NONE;
                        best_idx  <= '0;
                        best_age  <= '0;
                        off_found <= 1'b0;
                        off_idx   <= '0;
                        EVT_READY <= 1'b0;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    EVT_READY <= 1'b0;
                    if (evt_on) begin
                        if (retrig_c && (best_kind != CAND_RETRIG)) begin
                            best_kind <= CAND_RETRIG;
                            best_idx  <= idx;
                        end else if (free_c && (best_kind == CAND_NONE || best_kind == CAND_STEAL)) begin
                            best_kind <= CAND_FREE;
                            best_idx  <= idx;
                        end else if ((best_kind == CAND_NONE) ||
                                     ((best_kind == CAND_STEAL) && age_gt_c)) begin
                            best_kind <= CAND_STEAL;
                            best_idx  <= idx;
                            best_age  <= age_c;
                        end
                    end else if (held_match_c && !off_found) begin
                        off_found <= 1'b1;
                        off_idx   <= idx;
                    end
                    if (idx == SEL_W'(NUM_VOICES - 1)) begin
                        state <= ST_ISSUE;
                    end else begin
                        idx <= idx + SEL_W'(1);
                    end
                end
                ST_ISSUE: begin
                    state <= ST_IDLE;
                    if (do_load_c) begin
                        V_LD                <= 1'b1;
                        V_NOTE_ON           <= 1'b1;
                        V_SEL               <= best_idx;
                        V_KEY               <= evt_key;
                        V_VEL               <= evt_vel;
`ifdef VOICE_STEAL_EN
                        STEAL               <= (best_kind == CAND_STEAL);
`endif
                        tbl[best_idx].key   <= evt_key;
                        tbl[best_idx].held  <= 1'b1;
                        tbl[best_idx].stamp <= STAMP_MAX_W'(stamp_ctr);
                        stamp_ctr           <= stamp_ctr + STAMP_W'(1);
                    end else if (!evt_on && off_found) begin
                        V_NOTE_OFF         <= 1'b1;
                        V_SEL              <= off_idx;
                        tbl[off_idx].held  <= 1'b0;
                    end else begin
                        DROP <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (NUM_VOICES = 4): the driver queues the
// expected strobe and its arrival cycle, a monitor compares whenever a strobe appears.
module tb_voice_allocator;

    localparam int NV = 4;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          EVT_VALID = 1'b0;
    logic          EVT_READY;
    logic          EVT_ON = 1'b0;
    logic [6:0]    EVT_KEY = '0;
    logic [6:0]    EVT_VEL = '0;
    logic [NV-1:0] VOICE_ACTIVE = '0;
    logic [1:0]    V_SEL;
    logic [6:0]    V_KEY;
    logic [6:0]    V_VEL;
    logic          V_LD;
    logic          V_NOTE_ON;
    logic          V_NOTE_OFF;
    logic          STEAL;
    logic          DROP;

    voice_allocator #(
        .NUM_VOICES (NV),
        .STAMP_W    (8)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .EVT_VALID    (EVT_VALID),
        .EVT_READY    (EVT_READY),
        .EVT_ON       (EVT_ON),
        .EVT_KEY      (EVT_KEY),
        .EVT_VEL      (EVT_VEL),
        .VOICE_ACTIVE (VOICE_ACTIVE),
        .V_SEL        (V_SEL),
        .V_KEY        (V_KEY),
        .V_VEL        (V_VEL),
        .V_LD         (V_LD),
        .V_NOTE_ON    (V_NOTE_ON),
        .V_NOTE_OFF   (V_NOTE_OFF),
        .STEAL        (STEAL),
        .DROP         (DROP)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       ld;
        logic       on;
        logic       off;
        logic       steal;
        logic       drop;
        logic [1:0] sel;
        logic [6:0] key;
        logic [6:0] vel;
    } obs_t;

    typedef struct {
        obs_t o;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    obs_t mon_a;
    exp_t mon_e;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic obs_t mk(input logic ld, input logic off, input logic steal,
                                input logic drop, input int sel, input int key, input int vel);
        obs_t o;
        o.ld    = ld;
        o.on    = ld;
        o.off   = off;
        o.steal = steal;
        o.drop  = drop;
        o.sel   = drop ? 2'd0 : 2'(sel);
        o.key   = ld ? 7'(key) : 7'd0;
        o.vel   = ld ? 7'(vel) : 7'd0;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: any strobe must match the head of the queue, in content and cycle.
    always @(negedge CLK) begin
        if (RESET_N && (V_LD || V_NOTE_ON || V_NOTE_OFF || STEAL || DROP)) begin
            mon_a.ld    = V_LD;
            mon_a.on    = V_NOTE_ON;
            mon_a.off   = V_NOTE_OFF;
            mon_a.steal = STEAL;
            mon_a.drop  = DROP;
            mon_a.sel   = DROP ? 2'd0 : V_SEL;
            mon_a.key   = V_LD ? V_KEY : 7'd0;
            mon_a.vel   = V_LD ? V_VEL : 7'd0;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe got=%h at cycle %0d", mon_a, cyc);
            end else begin
                mon_e = q.pop_front();
                if (mon_a !== mon_e.o) begin
                    fails++;
                    $display("FAIL strobe got=%h want=%h", mon_a, mon_e.o);
                end
                tests++;
                if (cyc != mon_e.cyc) begin
                    fails++;
                    $display("FAIL latency got_cycle=%0d want_cycle=%0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    // Issue one event; called at a negedge. Expected strobe lands NV+1 edges after accept.
    task automatic send(input logic on, input int key, input int vel, input obs_t ex);
        int n;
        n = 0;
        EVT_ON    = on;
        EVT_KEY   = 7'(key);
        EVT_VEL   = 7'(vel);
        EVT_VALID = 1'b1;
        while (!EVT_READY && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!EVT_READY) begin
            check("ready_timeout", 32'(EVT_READY), 32'd1);
            EVT_VALID = 1'b0;
            return;
        end
        @(negedge CLK);
        EVT_VALID = 1'b0;
        q.push_back('{o: ex, cyc: cyc + NV + 1});
        repeat (NV + 4) @(negedge CLK);
        check("queue_drained", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_ready", 32'(EVT_READY), 32'd0);
        check("reset_strobes", 32'({V_LD, V_NOTE_ON, V_NOTE_OFF, STEAL, DROP, V_SEL, V_KEY, V_VEL}), 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("ready_after_release", 32'(EVT_READY), 32'd1);

        // Fill all four voices in order.
        send(1'b1, 60, 100, mk(1, 0, 0, 0, 0, 60, 100));
        send(1'b1, 62, 100, mk(1, 0, 0, 0, 1, 62, 100));
        send(1'b1, 64, 100, mk(1, 0, 0, 0, 2, 64, 100));
        send(1'b1, 65, 100, mk(1, 0, 0, 0, 3, 65, 100));

        // Table full: steal the oldest, or drop when stealing is disabled.
`ifdef VOICE_STEAL_EN
        send(1'b1, 67, 100, mk(1, 0, 1, 0, 0, 67, 100));
`else
        send(1'b1, 67, 100, mk(0, 0, 0, 1, 0, 0, 0));
`endif

        send(1'b0, 62, 0, mk(0, 1, 0, 0, 1, 0, 0));
        send(1'b0, 62, 0, mk(0, 0, 0, 1, 0, 0, 0));
        send(1'b1, 64, 0, mk(0, 1, 0, 0, 2, 0, 0));

        // Released-but-sounding voice 1 is retriggered by its own key.
        VOICE_ACTIVE = 4'b0010;
        send(1'b1, 62, 90, mk(1, 0, 0, 0, 1, 62, 90));
        send(1'b0, 62, 0, mk(0, 1, 0, 0, 1, 0, 0));
        VOICE_ACTIVE = 4'b0000;
        send(1'b1, 70, 80, mk(1, 0, 0, 0, 1, 70, 80));

        // Reset during SCAN: nothing may be emitted.
        EVT_ON    = 1'b1;
        EVT_KEY   = 7'd75;
        EVT_VEL   = 7'd50;
        EVT_VALID = 1'b1;
        check("ready_before_abort", 32'(EVT_READY), 32'd1);
        @(negedge CLK);
        EVT_VALID = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("ready_in_reset", 32'(EVT_READY), 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("ready_after_abort", 32'(EVT_READY), 32'd1);
        repeat (NV + 4) @(negedge CLK);
        check("no_strobe_after_abort", 32'(q.size()), 32'd0);

        send(1'b1, 72, 40, mk(1, 0, 0, 0, 0, 72, 40));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Maps incoming MIDI note events (key, velocity, on/off) onto NUM_VOICES parallel synth voice slots inside synth_ip.
- Issues per-voice load strobes (key, velocity, note-on, note-off) that drive each voice's LD_KEY/LD_VEL/LD_PLAY/NOTE_ON/NOTE_END inputs.
- Sits between the Avalon/USB MIDI decode front end and the voice array; the per-voice sample datapath feeding the audio FIFO is untouched.
- When no slot is free, the allocator steals the oldest voice.

Parameters:
- NUM_VOICES, 4, number of voice slots (power of two, 2..16)
- STAMP_W, 8, width of the allocation age stamp counter

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- EVT_VALID  in  1  note event present
- EVT_READY  out  1  allocator can accept an event
- EVT_ON  in  1  1 = note-on, 0 = note-off
- EVT_KEY  in  7  MIDI key number
- EVT_VEL  in  7  MIDI velocity
- VOICE_ACTIVE  in  NUM_VOICES  per-voice "still sounding" flag, including release phase
- V_SEL  out  $clog2(NUM_VOICES)  target voice index for the strobes below
- V_KEY  out  7  key to load
- V_VEL  out  7  velocity to load
- V_LD  out  1  one-cycle pulse: load V_KEY/V_VEL into voice V_SEL
- V_NOTE_ON  out  1  one-cycle pulse: start envelope of V_SEL (coincident with V_LD)
- V_NOTE_OFF  out  1  one-cycle pulse: enter release on V_SEL
- STEAL  out  1  one-cycle pulse: the current V_LD reused a busy voice
- DROP  out  1  one-cycle pulse: event discarded

Behaviour:
- Handshake: event accepted on the CLK edge where EVT_VALID && EVT_READY; EVT_KEY, EVT_VEL and EVT_ON are latched on that edge. EVT_READY = 1 only in IDLE.
- MIDI rule: note-on with EVT_VEL == 0 is handled as a note-off.
- Per-voice table (registers):
  - key[6:0]
  - held (note-on received, note-off not yet received)
  - stamp[STAMP_W-1:0]
- Global stamp counter: increments on every allocation; wraps modulo 2^STAMP_W.
- Voice age = (stamp_ctr - stamp[v]) mod 2^STAMP_W. Age is correct while fewer than 2^STAMP_W allocations separate two voices.
- FSM states: IDLE, SCAN, ISSUE.
  - IDLE -> SCAN on accept.
  - SCAN visits voice index 0..NUM_VOICES-1, one per cycle; ISSUE follows the last index.
  - ISSUE lasts one cycle, asserts the outputs below, then -> IDLE.
- Note-on candidate priority, evaluated during SCAN:
  1. Voice with key == EVT_KEY that is held or active (retrigger).
  2. Lowest-index voice with !held && !VOICE_ACTIVE (free).
  3. Voice with the largest age; ties go to the lowest index (steal).
- ISSUE for note-on:
  - Asserts V_LD and V_NOTE_ON with V_SEL/V_KEY/V_VEL.
  - Writes table: key, held = 1, stamp = stamp_ctr; then increments stamp_ctr.
  - STEAL = 1 only in the priority-3 case.
- ISSUE for note-off:
  - First held voice with matching key: V_NOTE_OFF = 1, held cleared.
  - No match: DROP = 1 and no voice strobe.
- Latency: accept edge to strobe cycle = NUM_VOICES + 1 cycles. Back-to-back throughput = one event per NUM_VOICES + 2 cycles.
- Simultaneous events: VOICE_ACTIVE may change during SCAN; a voice's value is sampled when that voice is visited.
- Reset values:
  - EVT_READY = 0 during reset, 1 in the first cycle after release.
  - All strobes, V_SEL, V_KEY, V_VEL = 0.
  - Table cleared (held = 0, stamp = 0); stamp_ctr = 0; state = IDLE.
- Reset mid-operation: an in-flight event is lost and no strobe is emitted.

Optional Feature:
- VOICE_STEAL_EN defined: priority-3 steal behaves as above.
- VOICE_STEAL_EN undefined: when no retrigger or free voice exists, a note-on produces DROP = 1, no V_LD, and no stamp increment. STEAL is tied to 0.

Decomposition:
- Package synth_pkg holds:
  - the voice-table entry struct (key, held, stamp)
  - the FSM state enum
  - MIDI constants KEY_W = 7 and VEL_W = 7
- One sub-module, voice_scan_cmp: combinational per-voice candidate compare producing retrigger/free/age-greater flags. It is instanced once and fed the scanned entry and the running best candidate.

Test Plan (NUM_VOICES = 4):
- Reset release, 4 note-ons with keys 60,62,64,65, velocity 100, VOICE_ACTIVE = 0 -> V_LD on V_SEL 0,1,2,3 in order; each strobe arrives 5 cycles after accept; STEAL = 0.
- Fifth note-on, key 67, all voices held -> V_SEL = 0 (oldest), STEAL = 1 (with VOICE_STEAL_EN); without the macro -> DROP = 1, no V_LD.
- Note-off for key 62 -> V_NOTE_OFF with V_SEL = 1. Repeating the note-off for key 62 -> DROP = 1.
- Note-on for key 64 with velocity 0 -> V_NOTE_OFF on V_SEL = 2, with no V_LD.
- Voice 1 released with VOICE_ACTIVE[1] = 1, then note-on for key 62 -> retrigger on V_SEL = 1; once VOICE_ACTIVE[1] = 0, a new key takes voice 1 as a free voice.
- Assert RESET_N low during SCAN -> no strobe is emitted; EVT_READY = 1 in the first cycle after release; the next note-on maps to V_SEL = 0.
